mult_sequencer: RTL and testbench

//  - Multi-cycle sequencer for MIPS mult/multu. Produces a 64-bit {hi,lo} product.
//  - Sequences the shared 32-bit ALU with a shift-add algorithm (one bit per cycle).
//  - Sits beside the execute stage. The pipeline stalls on busy and writes hi/lo on done.

---
 rtl/alu_pkg.sv | 47 ++++
 rtl/mult_sequencer_alu.sv | 43 ++++
 rtl/mult_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_mult_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the shared 32-bit ALU and the multiply sequencer.
//   - ALU control encodings used by the execute stage and by mult_sequencer.
//   - The multiply sequencer state enumeration.
//   - A small helper that recovers the carry out of an unsigned 32-bit add
//     when the ALU itself does not expose one.
// ----------------------------------------------------------------------------
package alu_pkg;

    // Width of the shared datapath.
    localparam int ALU_WIDTH = 32;

    // ALU control encodings.
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SRL  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1011;

    // Multiply sequencer states.
    //   IDLE : waiting for start, ALU released back to the pipeline
    //   NEGA : take magnitude of the multiplicand (signed only)
    //   NEGB : take magnitude of the multiplier (signed only)
    //   ITER : one shift-add step per cycle
    //   FIX  : negate the 64-bit product when the operand signs differ
    //   DONE : one-cycle completion pulse
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        NEGA = 3'd1,
        NEGB = 3'd2,
        ITER = 3'd3,
        FIX  = 3'd4,
        DONE = 3'd5
    } multState_t;

    // An unsigned add wrapped around exactly when the result is smaller
    // than the original augend.
    function automatic logic addCarryOut(input logic [ALU_WIDTH-1:0] sum,
                                         input logic [ALU_WIDTH-1:0] augend);
        return (sum < augend);
    endfunction

endpackage

// File: rtl/mult_sequencer_alu.sv
// ----------------------------------------------------------------------------
// mult_sequencer_alu
// The pipeline's combinational 32-bit ALU, instantiated here so the multiply
// sequencer can borrow it while the pipeline is stalled.
// Ports:
//   a_i      in  32  operand A (rs)
//   b_i      in  32  operand B (rt)
//   ctrl_i   in   4  operation select (alu_pkg ALU_* encodings)
//   shamt_i  in   5  shift amount for SLL/SRL
//   result_o out 32  operation result
//   zero_o   out  1  result is zero (branch compare)
// ----------------------------------------------------------------------------
module mult_sequencer_alu
    import alu_pkg::*;
(
    input  logic [ALU_WIDTH-1:0] a_i,
    input  logic [ALU_WIDTH-1:0] b_i,
    input  logic [3:0]           ctrl_i,
    input  logic [4:0]           shamt_i,
    output logic [ALU_WIDTH-1:0] result_o,
    output logic                 zero_o
);

    // Operation decode; unknown encodings produce zero so the result is
    // always defined.
    always_comb begin
        result_o = '0;
        case (ctrl_i)
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SLL:  result_o = b_i << shamt_i;
            ALU_SRL:  result_o = b_i >> shamt_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_SLT:  result_o = {{(ALU_WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SLTU: result_o = {{(ALU_WIDTH-1){1'b0}}, (a_i < b_i)};
            default:  result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/mult_sequencer.sv
// ----------------------------------------------------------------------------
// mult_sequencer
// Multi-cycle sequencer for MIPS mult/multu. It borrows the shared ALU and
// runs a one-bit-per-cycle shift-add algorithm to build a 64-bit {hi,lo}
// product. The pipeline stalls while busy is high and writes hi/lo on done.
//
// Signed multiplies are done on magnitudes: NEGA/NEGB make the operands
// positive, the unsigned core runs, and FIX negates the product if the
// operand signs differed. multu skips straight from IDLE to ITER.
//   multu : done 33 cycles after the start cycle
//   mult  : done 36 cycles after the start cycle
//
// Parameters:
//   WIDTH  operand width, only 32 is supported (product is 2*WIDTH)
//   ITERS  number of shift-add iterations, must equal WIDTH
// Ports:
//   clk           in   1   clock, rising edge
//   reset         in   1   asynchronous active-high reset
//   start         in   1   request, sampled only in IDLE
//   isSigned      in   1   1 = mult, 0 = multu, sampled with start
//   multiplicand  in  32   operand A (rs), sampled with start
//   multiplier    in  32   operand B (rt), sampled with start
//   busy          out  1   high in every state except IDLE
//   done          out  1   one-cycle pulse, hi/lo valid from this cycle
//   hi            out 32   product[63:32], registered
//   lo            out 32   product[31:0], registered
// ----------------------------------------------------------------------------
module mult_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITERS = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             isSigned,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(ITERS);
    localparam logic [CW-1:0] LAST_COUNT = CW'(ITERS - 1);

    // Sequencer state and datapath registers. The multiplier is loaded into
    // lo and shifts out of its bottom bit while product bits shift in at
    // the top, so no separate multiplier register is needed.
    multState_t     stateQ, stateD;
    logic [WIDTH-1:0] aQ, aD;
    logic [WIDTH-1:0] hiQ, hiD;
    logic [WIDTH-1:0] loQ, loD;
    logic [CW-1:0]    countQ, countD;
    logic             signedQ, signedD;
    logic             negAQ, negAD;
    logic             negBQ, negBD;

    // Shared ALU interface.
    logic [WIDTH-1:0] aluA;
    logic [WIDTH-1:0] aluB;
    logic [3:0]       aluCtrl;
    logic [WIDTH-1:0] aluResult;
    logic             aluZeroUnused;

    // Local helpers beside the ALU.
    logic             iterCarry;
    logic [WIDTH-1:0] hiNegated;

    mult_sequencer_alu uAlu (
        .a_i      (aluA),
        .b_i      (aluB),
        .ctrl_i   (aluCtrl),
        .shamt_i  (5'd0),
        .result_o (aluResult),
        .zero_o   (aluZeroUnused)
    );

    // The ALU only adds 32 bits, so the carry into the 33rd product bit is
    // recovered by comparing the sum against the old hi.
    assign iterCarry = addCarryOut(aluResult, hiQ);

    // Upper half of a 64-bit two's complement negate: invert, and propagate
    // the +1 only when the lower half negated to zero (old lo was zero).
    assign hiNegated = ~hiQ + WIDTH'(loQ == '0);

    // State and datapath registers. Reset aborts any operation in flight
    // and clears the result, so no done pulse can follow a reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ  <= IDLE;
            aQ      <= '0;
            hiQ     <= '0;
            loQ     <= '0;
            countQ  <= '0;
            signedQ <= 1'b0;
            negAQ   <= 1'b0;
            negBQ   <= 1'b0;
        end else begin
            stateQ  <= stateD;
            aQ      <= aD;
            hiQ     <= hiD;
            loQ     <= loD;
            countQ  <= countD;
            signedQ <= signedD;
            negAQ   <= negAD;
            negBQ   <= negBD;
        end
    end

    // Next-state, datapath and ALU operand selection. Everything holds by
    // default, and the ALU sees zero operands with the AND code outside the
    // working states so it does not toggle while the pipeline owns it.
    always_comb begin
        stateD  = stateQ;
        aD      = aQ;
        hiD     = hiQ;
        loD     = loQ;
        countD  = countQ;
        signedD = signedQ;
        negAD   = negAQ;
        negBD   = negBQ;
        aluA    = '0;
        aluB    = '0;
        aluCtrl = ALU_AND;

        case (stateQ)
            IDLE: begin
                if (start) begin
                    aD      = multiplicand;
                    loD     = multiplier;
                    hiD     = '0;
                    signedD = isSigned;
                    negAD   = 1'b0;
                    negBD   = 1'b0;
                    countD  = '0;
                    stateD  = isSigned ? NEGA : ITER;
                end
            end

            // 0x80000000 negates to itself, which read as unsigned is the
            // correct magnitude 2^31.
            NEGA: begin
                aluA    = '0;
                aluB    = aQ;
                aluCtrl = ALU_SUB;
                negAD   = aQ[WIDTH-1];
                if (aQ[WIDTH-1]) begin
                    aD = aluResult;
                end
                stateD  = NEGB;
            end

            NEGB: begin
                aluA    = '0;
                aluB    = loQ;
                aluCtrl = ALU_SUB;
                negBD   = loQ[WIDTH-1];
                if (loQ[WIDTH-1]) begin
                    loD = aluResult;
                end
                stateD  = ITER;
            end

            // One shift-add step: add the multiplicand when the current
            // multiplier bit is set, then shift the 65-bit {carry,sum,lo}
            // right by one.
            ITER: begin
                aluA    = hiQ;
                aluB    = loQ[0] ? aQ : '0;
                aluCtrl = ALU_ADD;
                hiD     = {iterCarry, aluResult[WIDTH-1:1]};
                loD     = {aluResult[0], loQ[WIDTH-1:1]};
                countD  = countQ + CW'(1);
                if (countQ == LAST_COUNT) begin
                    stateD = signedQ ? FIX : DONE;
                end
            end

            // Always visited for mult so latency does not depend on data;
            // the product is only changed when exactly one operand was
            // negative.
            FIX: begin
                aluA    = '0;
                aluB    = loQ;
                aluCtrl = ALU_SUB;
                if (negAQ ^ negBQ) begin
                    loD = aluResult;
                    hiD = hiNegated;
                end
                stateD  = DONE;
            end

            DONE: begin
                stateD = IDLE;
            end

            default: begin
                stateD = IDLE;
            end
        endcase
    end

    // Status is decoded straight from the registered state, so both are
    // glitch-free and drop immediately on reset.
    assign busy = (stateQ != IDLE);
    assign done = (stateQ == DONE);
    assign hi   = hiQ;
    assign lo   = loQ;

endmodule

// File: tb/tb_mult_sequencer.sv
// ----------------------------------------------------------------------------
// tb_mult_sequencer
// Self-checking bench for mult_sequencer: a table of directed multiplies
// with hand-computed products and latencies, followed by hand-written
// sequences for ignored starts and an asynchronous mid-operation reset.
// Inputs are driven and outputs sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_mult_sequencer;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        int          expLat;
    } vector_t;

    localparam int NUM_VECS = 10;
    localparam int MAX_WAIT = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        isSigned;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    vector_t vecs [NUM_VECS];

    mult_sequencer #(
        .WIDTH (32),
        .ITERS (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .isSigned     (isSigned),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .hi           (hi),
        .lo           (lo)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // One comparison; every failure prints a single FAIL line.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Issue one request and wait for done. lat is the number of rising
    // edges from the start edge to the cycle where done is seen; busyLow
    // counts cycles in that window where busy was not high. Operands and
    // isSigned are scrambled right after the start cycle, since the design
    // must ignore them while busy.
    task automatic applyStimulus(input logic sgn, input logic [31:0] a,
                                 input logic [31:0] b, output int lat,
                                 output int busyLow);
        @(negedge clk);
        start        = 1'b1;
        isSigned     = sgn;
        multiplicand = a;
        multiplier   = b;
        @(negedge clk);
        start        = 1'b0;
        isSigned     = ~sgn;
        multiplicand = $urandom;
        multiplier   = $urandom;
        lat          = 1;
        busyLow      = 0;
        while (done !== 1'b1 && lat < MAX_WAIT) begin
            if (busy !== 1'b1) busyLow++;
            @(negedge clk);
            lat++;
        end
        if (busy !== 1'b1) busyLow++;
    endtask

    initial begin
        int lat;
        int busyLow;
        int doneCount;
        int firstDone;

        vecs[0] = '{1'b0, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F, 33};
        vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33};
        vecs[2] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 33};
        vecs[3] = '{1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 33};
        vecs[4] = '{1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 36};
        vecs[5] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 36};
        vecs[6] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 36};
        vecs[7] = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 36};
        vecs[8] = '{1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 36};
        vecs[9] = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0000, 36};

        reset        = 1'b1;
        start        = 1'b0;
        isSigned     = 1'b0;
        multiplicand = '0;
        multiplier   = '0;

        // Reset state.
        #12;
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_hi",   64'(hi),   64'd0);
        checkOutput("reset_lo",   64'(lo),   64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed product table.
        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b, lat, busyLow);
            checkOutput($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].expLat));
            checkOutput($sformatf("vec%0d_busy", i), 64'(busyLow), 64'd0);
            checkOutput($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].expHi));
            checkOutput($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].expLo));
            @(negedge clk);
            checkOutput($sformatf("vec%0d_donePulse", i), 64'(done), 64'd0);
            checkOutput($sformatf("vec%0d_idleBusy", i), 64'(busy), 64'd0);
            checkOutput($sformatf("vec%0d_hold", i), {hi, lo}, {vecs[i].expHi, vecs[i].expLo});
        end

        // Starts while busy: one in ITER at t+10, one in the DONE cycle.
        // Neither may be accepted or queued; 0x10000 squared is 2^32.
        @(negedge clk);
        start        = 1'b1;
        isSigned     = 1'b0;
        multiplicand = 32'h0001_0000;
        multiplier   = 32'h0001_0000;
        @(negedge clk);
        start     = 1'b0;
        doneCount = 0;
        firstDone = 0;
        for (int k = 1; k <= 80; k++) begin
            if (done === 1'b1) begin
                doneCount++;
                if (firstDone == 0) firstDone = k;
            end
            start        = (k == 10) || (done === 1'b1);
            isSigned     = 1'b1;
            multiplicand = 32'hFFFF_FFFF;
            multiplier   = 32'hFFFF_FFFF;
            @(negedge clk);
        end
        start = 1'b0;
        checkOutput("ignore_firstDone", 64'(firstDone), 64'd33);
        checkOutput("ignore_doneCount", 64'(doneCount), 64'd1);
        checkOutput("ignore_result", {hi, lo}, 64'h0000_0001_0000_0000);
        checkOutput("ignore_idle", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of a mult, between clock edges.
        @(negedge clk);
        start        = 1'b1;
        isSigned     = 1'b1;
        multiplicand = 32'h7FFF_FFFF;
        multiplier   = 32'h7FFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        checkOutput("abort_busyBefore", 64'(busy), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_done", 64'(done), 64'd0);
        checkOutput("abort_hi",   64'(hi),   64'd0);
        checkOutput("abort_lo",   64'(lo),   64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abort_idleBusy", 64'(busy), 64'd0);
        checkOutput("abort_idleDone", 64'(done), 64'd0);

        // Normal operation after the abort.
        applyStimulus(1'b0, 32'h0000_0007, 32'h0000_0006, lat, busyLow);
        checkOutput("post_latency", 64'(lat), 64'd33);
        checkOutput("post_busy", 64'(busyLow), 64'd0);
        checkOutput("post_hi", 64'(hi), 64'd0);
        checkOutput("post_lo", 64'(lo), 64'h2A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
